// File: rtl/pack_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pack_sched_pkg
// Description : Shared types and helpers for the packer round-robin
//               scheduler. Holds the FSM state encoding, integer ceil_div and
//               clog2 helpers, and the beats-per-word derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package pack_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(4) = 2, ...
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int num_beats(input int out_w, input int in_w);
    return ceil_div(out_w, in_w);
  endfunction

endpackage : pack_sched_pkg
`default_nettype wire

// File: rtl/pack_rr_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Pointer-based round-robin arbiter. The grant is purely
//               combinational: the first asserted request found searching
//               upward from the pointer, with wrap. The pointer is registered
//               and moves to one past the served index when advance is high.
// Ports       : clk, rst_n      - clock, async active-low reset
//               clr             - synchronous pointer clear (wins over advance)
//               req             - request vector
//               advance/adv_idx - move pointer to adv_idx+1 (mod NUM_REQ)
//               grant_idx/vld   - combinational grant result
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [ID_W-1:0]    adv_idx,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  logic [ID_W-1:0] ptr_q;

  // Walk offsets from highest to lowest so the smallest offset from the
  // pointer is the last (and therefore winning) assignment.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % NUM_REQ]) begin
        grant_idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (clr) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (adv_idx == ID_W'(NUM_REQ - 1)) ? '0 : adv_idx + 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/pack_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : pack_rr_sched
// Description : Round-robin scheduler sharing one external packer_right
//               (IN_WIDTH beats -> OUT_WIDTH word) among NUM_REQ narrow
//               streams. One requester is granted per packed word; a word
//               cut short by Last is zero-padded, drained from the packer
//               into a tagged output register, then arbitration resumes.
// Ports       : clk, rst_n          - clock, async active-low reset
//               Reset               - synchronous clear / abort
//               Req_EnWr/RdyWr/DatWr/Last - per-requester beat streams
//               Pk_*                - connection to the external packer
//               Out_Vld/Rdy/Dat/Id/Last/Pad - packed word output register
// Revision    : 1.0 - initial release
// ============================================================================
module pack_rr_sched
  import pack_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int IN_WIDTH  = 64,
  parameter  int OUT_WIDTH = 128,
  localparam int NUM_BEATS = num_beats(OUT_WIDTH, IN_WIDTH),
  localparam int ID_W      = (clog2(NUM_REQ) > 1) ? clog2(NUM_REQ) : 1,
  localparam int CNT_W     = clog2(NUM_BEATS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          Req_EnWr,
  output logic [NUM_REQ-1:0]          Req_RdyWr,
  input  logic [NUM_REQ*IN_WIDTH-1:0] Req_DatWr,
  input  logic [NUM_REQ-1:0]          Req_Last,
  output logic                        Pk_Reset,
  output logic                        Pk_EnWr,
  input  logic                        Pk_RdyWr,
  output logic [IN_WIDTH-1:0]         Pk_DatWr,
  input  logic                        Pk_RdyRd,
  output logic                        Pk_EnRd,
  input  logic [OUT_WIDTH-1:0]        Pk_DatRd,
  output logic                        Out_Vld,
  input  logic                        Out_Rdy,
  output logic [OUT_WIDTH-1:0]        Out_Dat,
  output logic [ID_W-1:0]             Out_Id,
  output logic                        Out_Last,
  output logic [CNT_W-1:0]            Out_Pad
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  sched_state_t     state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] pad_q, pad_d;
  logic             last_seen_q, last_seen_d;

  logic [ID_W-1:0]  arb_idx;
  logic             arb_vld;
  logic             drain_fire;

  // The output register can take a word when it is empty or being emptied
  // on this edge; the sync Reset always suppresses the transfer.
  assign drain_fire = (state_q == ST_DRAIN) && (!Out_Vld || Out_Rdy)
                      && Pk_RdyRd && !Reset;

  assign Pk_Reset = Reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (Reset),
    .req       (Req_EnWr),
    .advance   (drain_fire),
    .adv_idx   (grant_q),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    pad_d       = pad_q;
    last_seen_d = last_seen_q;
    Req_RdyWr   = '0;
    Pk_EnWr     = 1'b0;
    Pk_DatWr    = '0;
    Pk_EnRd     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_d     = arb_idx;
          state_d     = ST_FILL;
          beat_cnt_d  = '0;
          pad_d       = '0;
          last_seen_d = 1'b0;
        end
      end

      ST_FILL: begin
        Req_RdyWr[grant_q] = Pk_RdyWr;
        Pk_DatWr           = Req_DatWr[int'(grant_q)*IN_WIDTH +: IN_WIDTH];
        Pk_EnWr            = Req_EnWr[grant_q] & Pk_RdyWr;
        if (Pk_EnWr) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d     = ST_DRAIN;
            last_seen_d = Req_Last[grant_q];
          end else if (Req_Last[grant_q]) begin
            state_d     = ST_PAD;
            last_seen_d = 1'b1;
            pad_d       = LAST_BEAT - beat_cnt_q;
          end
        end
      end

      // Zero beats are pushed until the packer holds a full word; the
      // running beat count doubles as the pad countdown.
      ST_PAD: begin
        Pk_EnWr = 1'b1;
        if (Pk_RdyWr) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (drain_fire) begin
          Pk_EnRd = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (Reset) begin
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
      Req_RdyWr  = '0;
      Pk_EnWr    = 1'b0;
      Pk_DatWr   = '0;
      Pk_EnRd    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      pad_q       <= '0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      pad_q       <= pad_d;
      last_seen_q <= last_seen_d;
    end
  end

  // Output register: a capture on the same edge as a consumer accept keeps
  // Out_Vld high with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_Vld  <= 1'b0;
      Out_Dat  <= '0;
      Out_Id   <= '0;
      Out_Last <= 1'b0;
      Out_Pad  <= '0;
    end else if (Reset) begin
      Out_Vld <= 1'b0;
    end else if (drain_fire) begin
      Out_Vld  <= 1'b1;
      Out_Dat  <= Pk_DatRd;
      Out_Id   <= grant_q;
      Out_Last <= last_seen_q;
      Out_Pad  <= pad_q;
    end else if (Out_Rdy) begin
      Out_Vld <= 1'b0;
    end
  end

  // The packer must present a full word for the whole time we sit in DRAIN.
  a_drain_has_word : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == ST_DRAIN) |-> Pk_RdyRd
  );

endmodule : pack_rr_sched
`default_nettype wire

// File: tb/tb_pack_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_pack_rr_sched
// Description : Directed self-checking bench for pack_rr_sched with a small
//               behavioural packer beside it, per-requester beat FIFOs and an
//               output capture list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pack_rr_sched;

  localparam int NR  = 4;
  localparam int IW  = 64;
  localparam int OW  = 128;
  localparam int NB  = 2;
  localparam int IDW = 2;
  localparam int CW  = 2;
  localparam int QD  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            Reset = 1'b0;
  logic [NR-1:0]   Req_EnWr, Req_RdyWr, Req_Last;
  logic [NR*IW-1:0] Req_DatWr;
  logic            Pk_Reset, Pk_EnWr, Pk_RdyWr, Pk_RdyRd, Pk_EnRd;
  logic [IW-1:0]   Pk_DatWr;
  logic [OW-1:0]   Pk_DatRd;
  logic            Out_Vld;
  logic            Out_Rdy = 1'b0;
  logic [OW-1:0]   Out_Dat;
  logic [IDW-1:0]  Out_Id;
  logic            Out_Last;
  logic [CW-1:0]   Out_Pad;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pack_rr_sched #(.NUM_REQ(NR), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .Reset(Reset),
    .Req_EnWr(Req_EnWr), .Req_RdyWr(Req_RdyWr), .Req_DatWr(Req_DatWr),
    .Req_Last(Req_Last),
    .Pk_Reset(Pk_Reset), .Pk_EnWr(Pk_EnWr), .Pk_RdyWr(Pk_RdyWr),
    .Pk_DatWr(Pk_DatWr), .Pk_RdyRd(Pk_RdyRd), .Pk_EnRd(Pk_EnRd),
    .Pk_DatRd(Pk_DatRd),
    .Out_Vld(Out_Vld), .Out_Rdy(Out_Rdy), .Out_Dat(Out_Dat), .Out_Id(Out_Id),
    .Out_Last(Out_Last), .Out_Pad(Out_Pad)
  );

  // ---------------- behavioural packer ----------------
  logic [OW-1:0] pk_buf;
  int            pk_cnt;
  assign Pk_RdyWr = (pk_cnt < NB);
  assign Pk_RdyRd = (pk_cnt == NB);
  assign Pk_DatRd = pk_buf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_cnt <= 0;
      pk_buf <= '0;
    end else if (Pk_Reset) begin
      pk_cnt <= 0;
      pk_buf <= '0;
    end else if (Pk_EnWr && Pk_RdyWr) begin
      pk_buf[pk_cnt*IW +: IW] <= Pk_DatWr;
      pk_cnt <= pk_cnt + 1;
    end else if (Pk_EnRd && Pk_RdyRd) begin
      pk_cnt <= 0;
      pk_buf <= '0;
    end
  end

  // ---------------- requester sources ----------------
  logic [IW:0]   sq [NR][QD];
  int            wp [NR];
  int            rp [NR];
  logic [NR-1:0] en = '0;

  always_comb begin
    Req_EnWr  = '0;
    Req_DatWr = '0;
    Req_Last  = '0;
    for (int i = 0; i < NR; i++) begin
      if (en[i] && (wp[i] != rp[i])) begin
        Req_EnWr[i]             = 1'b1;
        Req_DatWr[i*IW +: IW]   = sq[i][rp[i]][IW-1:0];
        Req_Last[i]             = sq[i][rp[i]][IW];
      end
    end
  end

  // ---------------- monitor ----------------
  int            cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NR-1:0] pend = '0;
  int            last_acc_cyc = 0;
  int            multi_rdy = 0;
  int            pkrst_cnt = 0;
  int            enrd_cnt = 0;
  logic [OW-1:0] rx_dat [64];
  logic [IDW-1:0] rx_id [64];
  logic          rx_last [64];
  logic [CW-1:0] rx_pad [64];
  int            rx_cyc [64];
  int            rx_n = 0;

  // Beats handshaken on a posedge are popped at the following negedge;
  // everything else is sampled 1 time unit after the negedge.
  always begin
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (pend[i]) rp[i] = rp[i] + 1;
    pend = '0;
    #1;
    if (rst_n) begin
      pend = Req_EnWr & Req_RdyWr;
      if (pend != '0) last_acc_cyc = cyc;
      if ($countones(Req_RdyWr) > 1) multi_rdy++;
      if (Pk_Reset) pkrst_cnt++;
      if (Pk_EnRd) enrd_cnt++;
      if (Out_Vld && Out_Rdy && rx_n < 64) begin
        rx_dat[rx_n]  = Out_Dat;
        rx_id[rx_n]   = Out_Id;
        rx_last[rx_n] = Out_Last;
        rx_pad[rx_n]  = Out_Pad;
        rx_cyc[rx_n]  = cyc;
        rx_n++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic push(input int r, input logic [IW-1:0] d, input logic l);
    sq[r][wp[r]] = {l, d};
    wp[r] = wp[r] + 1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (rx_n < n && k < budget) begin
      step(1);
      k++;
    end
    checks++;
    if (rx_n < n) begin
      failures++;
      $display("FAIL %s_timeout words=%0d required=%0d", name, rx_n, n);
    end
  endtask

  task automatic wait_pop(input int r, input int target, input string name);
    int k;
    k = 0;
    while (rp[r] < target && k < 40) begin
      step(1);
      k++;
    end
    checks++;
    if (rp[r] < target) begin
      failures++;
      $display("FAIL %s_beat_timeout popped=%0d required=%0d", name, rp[r], target);
    end
  endtask

  task automatic pulse_reset();
    step(1);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    rst_n = 1'b0;
    step(3);
    checks++;
    if ({Out_Vld, Out_Dat, Out_Id, Out_Last, Out_Pad} !== '0) begin
      failures++;
      $display("FAIL rst_out got vld=%b dat=%h id=%0d last=%b pad=%0d required all 0",
               Out_Vld, Out_Dat, Out_Id, Out_Last, Out_Pad);
    end
    rst_n = 1'b1;
    step(3);
    checks++;
    if (Out_Vld !== 1'b0) begin
      failures++;
      $display("FAIL rst_vld got=%b required=0", Out_Vld);
    end
    checks++;
    if ({Req_RdyWr, Pk_EnWr, Pk_EnRd, Pk_Reset} !== '0 || Pk_DatWr !== '0) begin
      failures++;
      $display("FAIL rst_ctrl got rdy=%b enwr=%b enrd=%b pkrst=%b required 0",
               Req_RdyWr, Pk_EnWr, Pk_EnRd, Pk_Reset);
    end
    checks++;
    if ({Out_Dat, Out_Id, Out_Last, Out_Pad} !== '0) begin
      failures++;
      $display("FAIL rst_outregs got dat=%h id=%0d required 0", Out_Dat, Out_Id);
    end
  endtask

  task automatic test_basic();
    int base;
    base = rx_n;
    Out_Rdy = 1'b1;
    en = 4'b0001;
    push(0, 64'hA, 1'b0);
    push(0, 64'hB, 1'b0);
    wait_rx(base + 1, 40, "basic");
    step(6);
    checks++;
    if (rx_dat[base] !== {64'hB, 64'hA}) begin
      failures++;
      $display("FAIL basic_dat got=%h required=%h", rx_dat[base], {64'hB, 64'hA});
    end
    checks++;
    if (rx_id[base] !== 2'd0 || rx_pad[base] !== 2'd0 || rx_last[base] !== 1'b0) begin
      failures++;
      $display("FAIL basic_tag got id=%0d pad=%0d last=%b required 0/0/0",
               rx_id[base], rx_pad[base], rx_last[base]);
    end
    checks++;
    if (rx_cyc[base] - last_acc_cyc !== 2) begin
      failures++;
      $display("FAIL basic_latency got=%0d required=2", rx_cyc[base] - last_acc_cyc);
    end
    checks++;
    if (rx_n !== base + 1) begin
      failures++;
      $display("FAIL basic_count got=%0d required=%0d", rx_n, base + 1);
    end
  endtask

  task automatic test_round_robin();
    int base;
    logic [OW-1:0] ed [4];
    logic [IDW-1:0] ei [4];
    pulse_reset();
    base = rx_n;
    multi_rdy = 0;
    en = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      push(0, 64'h10 + 64'(b), 1'b0);
      push(2, 64'h20 + 64'(b), 1'b0);
    end
    ed[0] = {64'h11, 64'h10}; ei[0] = 2'd0;
    ed[1] = {64'h21, 64'h20}; ei[1] = 2'd2;
    ed[2] = {64'h13, 64'h12}; ei[2] = 2'd0;
    ed[3] = {64'h23, 64'h22}; ei[3] = 2'd2;
    wait_rx(base + 4, 80, "rr");
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (rx_id[base+w] !== ei[w] || rx_dat[base+w] !== ed[w]) begin
        failures++;
        $display("FAIL rr_word%0d got id=%0d dat=%h required id=%0d dat=%h",
                 w, rx_id[base+w], rx_dat[base+w], ei[w], ed[w]);
      end
    end
    checks++;
    if (multi_rdy !== 0) begin
      failures++;
      $display("FAIL rr_multi_rdy got=%0d required=0", multi_rdy);
    end
  endtask

  task automatic test_pad_last();
    int base;
    base = rx_n;
    en = 4'b0010;
    push(1, 64'hC, 1'b1);
    wait_rx(base + 1, 40, "pad");
    checks++;
    if (rx_dat[base] !== {64'h0, 64'hC}) begin
      failures++;
      $display("FAIL pad_dat got=%h required=%h", rx_dat[base], {64'h0, 64'hC});
    end
    checks++;
    if (rx_pad[base] !== 2'd1 || rx_last[base] !== 1'b1 || rx_id[base] !== 2'd1) begin
      failures++;
      $display("FAIL pad_tag got pad=%0d last=%b id=%0d required 1/1/1",
               rx_pad[base], rx_last[base], rx_id[base]);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int enrd0;
    step(4);
    base = rx_n;
    Out_Rdy = 1'b0;
    en = 4'b0100;
    enrd0 = enrd_cnt;
    for (int b = 0; b < 4; b++) push(2, 64'h30 + 64'(b), 1'b0);
    step(20);
    checks++;
    if (Out_Vld !== 1'b1 || Out_Dat !== {64'h31, 64'h30} || Out_Id !== 2'd2) begin
      failures++;
      $display("FAIL bp_hold got vld=%b dat=%h id=%0d required 1/%h/2",
               Out_Vld, Out_Dat, Out_Id, {64'h31, 64'h30});
    end
    checks++;
    if (Req_RdyWr !== '0 || Pk_EnRd !== 1'b0 || Pk_RdyRd !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain_hold got rdy=%b enrd=%b pkfull=%b required 0/0/1",
               Req_RdyWr, Pk_EnRd, Pk_RdyRd);
    end
    checks++;
    if (enrd_cnt - enrd0 !== 1 || rx_n !== base) begin
      failures++;
      $display("FAIL bp_stall got enrd=%0d words=%0d required 1/%0d",
               enrd_cnt - enrd0, rx_n, base);
    end
    Out_Rdy = 1'b1;
    wait_rx(base + 2, 20, "bp");
    step(8);
    checks++;
    if (rx_n !== base + 2) begin
      failures++;
      $display("FAIL bp_count got=%0d required=%0d", rx_n, base + 2);
    end
    checks++;
    if (rx_dat[base] !== {64'h31, 64'h30} || rx_dat[base+1] !== {64'h33, 64'h32}) begin
      failures++;
      $display("FAIL bp_order got %h %h required %h %h", rx_dat[base], rx_dat[base+1],
               {64'h31, 64'h30}, {64'h33, 64'h32});
    end
  endtask

  task automatic test_sync_reset();
    int base;
    int rst0;
    base = rx_n;
    rst0 = pkrst_cnt;
    en = 4'b0001;
    push(0, 64'h99, 1'b0);
    wait_pop(0, rp[0] + 1, "srst");
    step(1);
    Reset = 1'b1;
    #1;
    checks++;
    if (Pk_Reset !== 1'b1 || Req_RdyWr !== '0 || Pk_EnWr !== 1'b0) begin
      failures++;
      $display("FAIL srst_gate got pkrst=%b rdy=%b enwr=%b required 1/0/0",
               Pk_Reset, Req_RdyWr, Pk_EnWr);
    end
    step(1);
    Reset = 1'b0;
    step(3);
    checks++;
    if (pkrst_cnt - rst0 !== 1 || Out_Vld !== 1'b0 || rx_n !== base) begin
      failures++;
      $display("FAIL srst_effect got pulses=%0d vld=%b words=%0d required 1/0/%0d",
               pkrst_cnt - rst0, Out_Vld, rx_n, base);
    end
    push(0, 64'hD, 1'b0);
    push(0, 64'hE, 1'b0);
    wait_rx(base + 1, 40, "srst");
    checks++;
    if (rx_dat[base] !== {64'hE, 64'hD} || rx_id[base] !== 2'd0) begin
      failures++;
      $display("FAIL srst_next got dat=%h id=%0d required %h/0", rx_dat[base],
               rx_id[base], {64'hE, 64'hD});
    end
  endtask

  task automatic test_drop_valid();
    int base;
    int bad;
    logic [OW-1:0] ed [3];
    logic [IDW-1:0] ei [3];
    step(4);
    base = rx_n;
    bad = 0;
    push(0, 64'h50, 1'b0);
    push(0, 64'h51, 1'b0);
    push(1, 64'h60, 1'b0);
    push(1, 64'h61, 1'b0);
    en = 4'b1000;
    push(3, 64'h40, 1'b0);
    wait_pop(3, rp[3] + 1, "drop");
    en = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (Req_RdyWr !== 4'b1000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL drop_grant_kept got bad_cycles=%0d required=0", bad);
    end
    push(3, 64'h41, 1'b0);
    en = 4'b1111;
    ed[0] = {64'h41, 64'h40}; ei[0] = 2'd3;
    ed[1] = {64'h51, 64'h50}; ei[1] = 2'd0;
    ed[2] = {64'h61, 64'h60}; ei[2] = 2'd1;
    wait_rx(base + 3, 60, "drop");
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (rx_id[base+w] !== ei[w] || rx_dat[base+w] !== ed[w]) begin
        failures++;
        $display("FAIL drop_word%0d got id=%0d dat=%h required id=%0d dat=%h",
                 w, rx_id[base+w], rx_dat[base+w], ei[w], ed[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_pad_last();
    test_backpressure();
    test_sync_reset();
    test_drop_valid();
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pack_rr_sched
`default_nettype wire
